axi4_mem_arbiter: RTL and testbench

//  2:1 AXI4-lite arbiter that shares axi4_mem_periph between two masters.

---
 rtl/axi4_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_axi4_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_arbiter.sv
// 2:1 AXI4-lite arbiter: one transaction at a time, round-robin grant, sticky watchdog error.
// Latency: 1 cycle IDLE decision, then slave-side channels forwarded combinationally.
// Backpressure: slave readies pass straight to the granted master; the loser sees all ready/valid low.
module axi4_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  // master 0
  input  logic                    m0_axi_awvalid,
  output logic                    m0_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
  input  logic [2:0]              m0_axi_awprot,
  input  logic                    m0_axi_wvalid,
  output logic                    m0_axi_wready,
  input  logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
  output logic                    m0_axi_bvalid,
  input  logic                    m0_axi_bready,
  input  logic                    m0_axi_arvalid,
  output logic                    m0_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
  input  logic [2:0]              m0_axi_arprot,
  output logic                    m0_axi_rvalid,
  input  logic                    m0_axi_rready,
  output logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  // master 1
  input  logic                    m1_axi_awvalid,
  output logic                    m1_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  input  logic [2:0]              m1_axi_awprot,
  input  logic                    m1_axi_wvalid,
  output logic                    m1_axi_wready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_bvalid,
  input  logic                    m1_axi_bready,
  input  logic                    m1_axi_arvalid,
  output logic                    m1_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  input  logic [2:0]              m1_axi_arprot,
  output logic                    m1_axi_rvalid,
  input  logic                    m1_axi_rready,
  output logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  // slave
  output logic                    s_axi_awvalid,
  input  logic                    s_axi_awready,
  output logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  output logic [2:0]              s_axi_awprot,
  output logic                    s_axi_wvalid,
  input  logic                    s_axi_wready,
  output logic [DATA_WIDTH-1:0]   s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_bvalid,
  output logic                    s_axi_bready,
  output logic                    s_axi_arvalid,
  input  logic                    s_axi_arready,
  output logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_rvalid,
  output logic                    s_axi_rready,
  input  logic [DATA_WIDTH-1:0]   s_axi_rdata,
  // status
  output logic [1:0]              grant,
  output logic                    timeout_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_XFER = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]      state;
  logic            rr_last;
  logic            aw_done;
  logic            w_done;
  logic [WD_W-1:0] wd;

  // Owner select; grant is one-hot so bit 1 alone picks the master.
  logic own1;
  assign own1 = grant[1];

  // Phases open per state; reset closes them in the very cycle it is sampled.
  logic open_aw, open_w, open_b, open_ar, open_r;
  assign open_ar = !reset && (state == RD_ADDR);
  assign open_r  = !reset && (state == RD_DATA);
  assign open_aw = !reset && (state == WR_XFER) && !aw_done;
  assign open_w  = !reset && (state == WR_XFER) && !w_done;
  assign open_b  = !reset && (state == WR_RESP);

  // Payload mux from the owner to the slave.
  assign s_axi_awaddr = own1 ? m1_axi_awaddr : m0_axi_awaddr;
  assign s_axi_awprot = own1 ? m1_axi_awprot : m0_axi_awprot;
  assign s_axi_wdata  = own1 ? m1_axi_wdata  : m0_axi_wdata;
  assign s_axi_wstrb  = own1 ? m1_axi_wstrb  : m0_axi_wstrb;
  assign s_axi_araddr = own1 ? m1_axi_araddr : m0_axi_araddr;
  assign s_axi_arprot = own1 ? m1_axi_arprot : m0_axi_arprot;

  // Slave-side valids/readies follow the owner only while the phase is open.
  assign s_axi_awvalid = open_aw && (own1 ? m1_axi_awvalid : m0_axi_awvalid);
  assign s_axi_wvalid  = open_w  && (own1 ? m1_axi_wvalid  : m0_axi_wvalid);
  assign s_axi_bready  = open_b  && (own1 ? m1_axi_bready  : m0_axi_bready);
  assign s_axi_arvalid = open_ar && (own1 ? m1_axi_arvalid : m0_axi_arvalid);
  assign s_axi_rready  = open_r  && (own1 ? m1_axi_rready  : m0_axi_rready);

  // Master-side readies/responses reach the owner only.
  assign m0_axi_awready = open_aw && grant[0] && s_axi_awready;
  assign m0_axi_wready  = open_w  && grant[0] && s_axi_wready;
  assign m0_axi_bvalid  = open_b  && grant[0] && s_axi_bvalid;
  assign m0_axi_arready = open_ar && grant[0] && s_axi_arready;
  assign m0_axi_rvalid  = open_r  && grant[0] && s_axi_rvalid;
  assign m0_axi_rdata   = s_axi_rdata;
  assign m1_axi_awready = open_aw && grant[1] && s_axi_awready;
  assign m1_axi_wready  = open_w  && grant[1] && s_axi_wready;
  assign m1_axi_bvalid  = open_b  && grant[1] && s_axi_bvalid;
  assign m1_axi_arready = open_ar && grant[1] && s_axi_arready;
  assign m1_axi_rvalid  = open_r  && grant[1] && s_axi_rvalid;
  assign m1_axi_rdata   = s_axi_rdata;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign b_hs  = s_axi_bvalid  && s_axi_bready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid  && s_axi_rready;

  // Arbitration: a lone requester wins; on a tie the master not served last wins.
  logic req0, req1, win1, win_rd;
  assign req0   = m0_axi_arvalid || m0_axi_awvalid;
  assign req1   = m1_axi_arvalid || m1_axi_awvalid;
  assign win1   = req1 && (!req0 || !rr_last);
  assign win_rd = win1 ? m1_axi_arvalid : m0_axi_arvalid;

  logic wd_expire;
  assign wd_expire = (TIMEOUT != 0) && (state != IDLE) && (wd == WD_W'(TIMEOUT - 1));

  // Transaction FSM with grant, round-robin pointer, write done flags and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 2'b00;
      rr_last     <= 1'b1;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      timeout_err <= 1'b0;
      wd          <= '0;
    end else begin
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (req0 || req1) begin
            grant <= win1 ? 2'b10 : 2'b01;
            state <= win_rd ? RD_ADDR : WR_XFER;
          end
        end
        RD_ADDR: if (ar_hs) state <= RD_DATA;
        RD_DATA: if (r_hs) begin
          state   <= IDLE;
          grant   <= 2'b00;
          rr_last <= own1;
        end
        WR_XFER: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WR_RESP;
        end
        WR_RESP: if (b_hs) begin
          state   <= IDLE;
          grant   <= 2'b00;
          rr_last <= own1;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
      // A hung slave abandons the owner; no response is ever delivered.
      if (wd_expire) begin
        state       <= IDLE;
        grant       <= 2'b00;
        rr_last     <= own1;
        timeout_err <= 1'b1;
      end
      if (state == IDLE || wd_expire || r_hs || b_hs) wd <= '0;
      else                                            wd <= wd + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Bench for axi4_mem_arbiter: directed master stimulus against a small register-ready memory slave.
// Latency: checks the 1-cycle grant decision and 16-cycle watchdog expiry.
// Backpressure: slave readies pulse one cycle after valid; rvalid/awready can be withheld.
module tb_axi4_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        m0_axi_awvalid = 0, m0_axi_awready;
  logic [31:0] m0_axi_awaddr = 0;
  logic [2:0]  m0_axi_awprot = 0;
  logic        m0_axi_wvalid = 0, m0_axi_wready;
  logic [31:0] m0_axi_wdata = 0;
  logic [3:0]  m0_axi_wstrb = 0;
  logic        m0_axi_bvalid, m0_axi_bready = 1;
  logic        m0_axi_arvalid = 0, m0_axi_arready;
  logic [31:0] m0_axi_araddr = 0;
  logic [2:0]  m0_axi_arprot = 0;
  logic        m0_axi_rvalid, m0_axi_rready = 1;
  logic [31:0] m0_axi_rdata;

  logic        m1_axi_awvalid = 0, m1_axi_awready;
  logic [31:0] m1_axi_awaddr = 0;
  logic [2:0]  m1_axi_awprot = 0;
  logic        m1_axi_wvalid = 0, m1_axi_wready;
  logic [31:0] m1_axi_wdata = 0;
  logic [3:0]  m1_axi_wstrb = 0;
  logic        m1_axi_bvalid, m1_axi_bready = 1;
  logic        m1_axi_arvalid = 0, m1_axi_arready;
  logic [31:0] m1_axi_araddr = 0;
  logic [2:0]  m1_axi_arprot = 0;
  logic        m1_axi_rvalid, m1_axi_rready = 1;
  logic [31:0] m1_axi_rdata;

  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  axi4_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready), .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awprot(m0_axi_awprot),
    .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready), .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb),
    .m0_axi_bvalid(m0_axi_bvalid), .m0_axi_bready(m0_axi_bready),
    .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready), .m0_axi_araddr(m0_axi_araddr), .m0_axi_arprot(m0_axi_arprot),
    .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready), .m0_axi_rdata(m0_axi_rdata),
    .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready), .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awprot(m1_axi_awprot),
    .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready), .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb),
    .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready),
    .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready), .m1_axi_araddr(m1_axi_araddr), .m1_axi_arprot(m1_axi_arprot),
    .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready), .m1_axi_rdata(m1_axi_rdata),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- memory slave stub (readies from registers) ----------------
  logic [31:0] mem [16];
  logic        no_rvalid = 0;
  logic        hold_aw = 0;
  logic        aw_got, w_got;
  logic [3:0]  wa;
  logic [31:0] wdl;
  logic [3:0]  wsl;

  // Stub: one-cycle ready pulses, read data one cycle after AR, B after both AW and W.
  always @(posedge clk) begin
    if (reset) begin
      s_axi_arready <= 0; s_axi_rvalid <= 0; s_axi_rdata <= 0;
      s_axi_awready <= 0; s_axi_wready <= 0; s_axi_bvalid <= 0;
      aw_got <= 0; w_got <= 0; wa <= 0; wdl <= 0; wsl <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else begin
      if (s_axi_arready) s_axi_arready <= 0;
      else               s_axi_arready <= s_axi_arvalid && !s_axi_rvalid;
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= !no_rvalid;
        s_axi_rdata  <= mem[s_axi_araddr[5:2]];
      end else if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 0;

      if (s_axi_awready) s_axi_awready <= 0;
      else               s_axi_awready <= s_axi_awvalid && !aw_got && !s_axi_bvalid && !hold_aw;
      if (s_axi_wready)  s_axi_wready <= 0;
      else               s_axi_wready <= s_axi_wvalid && !w_got && !s_axi_bvalid;
      if (s_axi_awvalid && s_axi_awready) begin aw_got <= 1; wa <= s_axi_awaddr[5:2]; end
      if (s_axi_wvalid && s_axi_wready) begin w_got <= 1; wdl <= s_axi_wdata; wsl <= s_axi_wstrb; end
      if (aw_got && w_got && !s_axi_bvalid) begin
        for (int b = 0; b < 4; b++) if (wsl[b]) mem[wa][8*b +: 8] <= wdl[8*b +: 8];
        s_axi_bvalid <= 1; aw_got <= 0; w_got <= 0;
      end
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 0;
    end
  end

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int rcnt0 = 0, rcnt1 = 0, bcnt0 = 0, bcnt1 = 0;
  int leak0 = 0, leak1 = 0;
  logic [31:0] rdata0 = 0, rdata1 = 0;
  int order[$];

  // One clock: log responses, count leaks to the loser, drop valids that handshook.
  task automatic step();
    logic c0ar, c0aw, c0w, c1ar, c1aw, c1w;
    c0ar = m0_axi_arvalid & m0_axi_arready;
    c0aw = m0_axi_awvalid & m0_axi_awready;
    c0w  = m0_axi_wvalid  & m0_axi_wready;
    c1ar = m1_axi_arvalid & m1_axi_arready;
    c1aw = m1_axi_awvalid & m1_axi_awready;
    c1w  = m1_axi_wvalid  & m1_axi_wready;
    if (m0_axi_rvalid && m0_axi_rready) begin rdata0 = m0_axi_rdata; rcnt0++; order.push_back(0); end
    if (m1_axi_rvalid && m1_axi_rready) begin rdata1 = m1_axi_rdata; rcnt1++; order.push_back(1); end
    if (m0_axi_bvalid && m0_axi_bready) begin bcnt0++; order.push_back(2); end
    if (m1_axi_bvalid && m1_axi_bready) begin bcnt1++; order.push_back(3); end
    if (!grant[0] && (m0_axi_arready | m0_axi_awready | m0_axi_wready | m0_axi_rvalid | m0_axi_bvalid)) leak0++;
    if (!grant[1] && (m1_axi_arready | m1_axi_awready | m1_axi_wready | m1_axi_rvalid | m1_axi_bvalid)) leak1++;
    @(negedge clk);
    if (c0ar) m0_axi_arvalid = 0;
    if (c0aw) m0_axi_awvalid = 0;
    if (c0w)  m0_axi_wvalid  = 0;
    if (c1ar) m1_axi_arvalid = 0;
    if (c1aw) m1_axi_awvalid = 0;
    if (c1w)  m1_axi_wvalid  = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_cmp++; if ({s_axi_arvalid, s_axi_awvalid, s_axi_wvalid, s_axi_rready, s_axi_bready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_slave_handshakes: got %b want 00000",
                        {s_axi_arvalid, s_axi_awvalid, s_axi_wvalid, s_axi_rready, s_axi_bready});
    end
  endtask

  task automatic test_single_read();
    leak1 = 0;
    m0_axi_araddr = 32'h0000_0100; m0_axi_arprot = 3'b010; m0_axi_arvalid = 1;
    n_cmp++; if (s_axi_arvalid !== 1'b0 || grant !== 2'b00) begin
      n_bad++; $display("FAIL rd_decision_latency: arvalid=%b grant=%b want 0/00", s_axi_arvalid, grant);
    end
    step();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rd_grant: got %b want 01", grant); end
    n_cmp++; if (s_axi_araddr !== 32'h0000_0100 || s_axi_arvalid !== 1'b1 || s_axi_arprot !== 3'b010) begin
      n_bad++; $display("FAIL rd_ar_forward: addr=%h valid=%b prot=%b want 00000100/1/010", s_axi_araddr, s_axi_arvalid, s_axi_arprot);
    end
    for (int i = 0; i < 40 && rcnt0 < 1; i++) step();
    n_cmp++; if (rcnt0 !== 1) begin n_bad++; $display("FAIL rd_complete: got %0d reads want 1", rcnt0); end
    n_cmp++; if (rdata0 !== 32'hA5A5_0000) begin n_bad++; $display("FAIL rd_data: got %h want a5a50000", rdata0); end
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rd_grant_release: got %b want 00", grant); end
    n_cmp++; if (leak1 !== 0) begin n_bad++; $display("FAIL rd_m1_quiet: got %0d leaks want 0", leak1); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    order.delete();
    rcnt0 = 0; rcnt1 = 0;
    m0_axi_araddr = 32'h104; m0_axi_arvalid = 1;
    m1_axi_araddr = 32'h108; m1_axi_arvalid = 1;
    step();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rr_first_tie: got %b want 01", grant); end
    for (int i = 0; i < 60 && (rcnt0 + rcnt1) < 2; i++) step();
    m0_axi_araddr = 32'h10C; m0_axi_arvalid = 1;
    m1_axi_araddr = 32'h110; m1_axi_arvalid = 1;
    for (int i = 0; i < 60 && (rcnt0 + rcnt1) < 4; i++) step();
    n_cmp++; if (order.size() !== 4) begin n_bad++; $display("FAIL rr_count: got %0d reads want 4", order.size()); end
    n_cmp++; if (order[0] !== 0 || order[1] !== 1) begin
      n_bad++; $display("FAIL rr_round1_order: got %0d,%0d want 0,1", order[0], order[1]);
    end
    n_cmp++; if (order[2] !== 0 || order[3] !== 1) begin
      n_bad++; $display("FAIL rr_round2_order: got %0d,%0d want 0,1", order[2], order[3]);
    end
    n_cmp++; if (rdata0 !== 32'hA5A5_0003 || rdata1 !== 32'hA5A5_0004) begin
      n_bad++; $display("FAIL rr_data: got %h,%h want a5a50003,a5a50004", rdata0, rdata1);
    end
  endtask

  task automatic test_write();
    bcnt1 = 0;
    m1_axi_awaddr = 32'h4000_0010; m1_axi_awprot = 3'b001; m1_axi_awvalid = 1;
    step();
    n_cmp++; if (grant !== 2'b10 || s_axi_awaddr !== 32'h4000_0010 || s_axi_awprot !== 3'b001) begin
      n_bad++; $display("FAIL wr_grant_aw: grant=%b addr=%h prot=%b want 10/40000010/001", grant, s_axi_awaddr, s_axi_awprot);
    end
    m1_axi_wdata = 32'hDEAD_BEEF; m1_axi_wstrb = 4'b0011; m1_axi_wvalid = 1;
    for (int i = 0; i < 40 && bcnt1 < 1; i++) step();
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (bcnt1 !== 1) begin n_bad++; $display("FAIL wr_single_b: got %0d B pulses want 1", bcnt1); end
    n_cmp++; if (mem[4] !== 32'hA5A5_BEEF) begin n_bad++; $display("FAIL wr_mem_strb: got %h want a5a5beef", mem[4]); end
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL wr_grant_release: got %b want 00", grant); end
  endtask

  task automatic test_read_before_write();
    order.delete();
    leak1 = 0; rcnt0 = 0; bcnt0 = 0;
    m0_axi_araddr = 32'h10C; m0_axi_arvalid = 1;
    m0_axi_awaddr = 32'h4000_0014; m0_axi_awvalid = 1;
    m0_axi_wdata = 32'h1234_5678; m0_axi_wstrb = 4'hF; m0_axi_wvalid = 1;
    for (int i = 0; i < 80 && (rcnt0 < 1 || bcnt0 < 1); i++) step();
    step();
    n_cmp++; if (order.size() !== 2) begin n_bad++; $display("FAIL rw_count: got %0d events want 2", order.size()); end
    n_cmp++; if (order[0] !== 0 || order[1] !== 2) begin
      n_bad++; $display("FAIL rw_order: got %0d,%0d want 0,2", order[0], order[1]);
    end
    n_cmp++; if (rdata0 !== 32'hA5A5_0003) begin n_bad++; $display("FAIL rw_rdata: got %h want a5a50003", rdata0); end
    n_cmp++; if (mem[5] !== 32'h1234_5678) begin n_bad++; $display("FAIL rw_mem: got %h want 12345678", mem[5]); end
    n_cmp++; if (leak1 !== 0) begin n_bad++; $display("FAIL rw_m1_quiet: got %0d leaks want 0", leak1); end
  endtask

  task automatic test_timeout();
    apply_reset();
    rcnt1 = 0;
    no_rvalid = 1;
    m1_axi_araddr = 32'h118; m1_axi_arvalid = 1;
    step();
    for (int i = 0; i < 15; i++) step();
    n_cmp++; if (timeout_err !== 1'b0 || grant !== 2'b10) begin
      n_bad++; $display("FAIL wd_before_expiry: err=%b grant=%b want 0/10", timeout_err, grant);
    end
    step();
    n_cmp++; if (timeout_err !== 1'b1 || grant !== 2'b00) begin
      n_bad++; $display("FAIL wd_expiry_cycle16: err=%b grant=%b want 1/00", timeout_err, grant);
    end
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (timeout_err !== 1'b1 || grant !== 2'b00 || rcnt1 !== 0) begin
      n_bad++; $display("FAIL wd_sticky: err=%b grant=%b reads=%0d want 1/00/0", timeout_err, grant, rcnt1);
    end
    no_rvalid = 0;
  endtask

  task automatic test_reset_mid_write();
    bcnt0 = 0;
    hold_aw = 1;
    m0_axi_awaddr = 32'h4000_0020; m0_axi_awvalid = 1;
    m0_axi_wdata = 32'hCAFE_F00D; m0_axi_wstrb = 4'hF; m0_axi_wvalid = 1;
    step();
    step();
    n_cmp++; if (s_axi_awvalid !== 1'b1 || grant !== 2'b01) begin
      n_bad++; $display("FAIL rst_mid_setup: awvalid=%b grant=%b want 1/01", s_axi_awvalid, grant);
    end
    reset = 1;
    #1;
    n_cmp++; if (s_axi_awvalid !== 1'b0 || s_axi_wvalid !== 1'b0) begin
      n_bad++; $display("FAIL rst_same_cycle: awvalid=%b wvalid=%b want 0/0", s_axi_awvalid, s_axi_wvalid);
    end
    @(negedge clk);
    n_cmp++; if ({s_axi_awvalid, s_axi_wvalid, s_axi_arvalid} !== 3'b000 || grant !== 2'b00 || timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_after: valids=%b grant=%b err=%b want 000/00/0",
                        {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid}, grant, timeout_err);
    end
    m0_axi_awvalid = 0; m0_axi_wvalid = 0; hold_aw = 0;
    reset = 0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (bcnt0 !== 0 || m0_axi_bvalid !== 1'b0) begin
      n_bad++; $display("FAIL rst_no_response: b=%0d bvalid=%b want 0/0", bcnt0, m0_axi_bvalid);
    end
    rcnt0 = 0;
    m0_axi_araddr = 32'h0000_0100; m0_axi_arvalid = 1;
    for (int i = 0; i < 40 && rcnt0 < 1; i++) step();
    n_cmp++; if (rcnt0 !== 1 || rdata0 !== 32'hA5A5_0000) begin
      n_bad++; $display("FAIL rst_recover_read: reads=%0d data=%h want 1/a5a50000", rcnt0, rdata0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_read_before_write();
    test_timeout();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
